rotary_rgb_ctrl: RTL and testbench

//  Menu controller between the incremental-encoder front end and the RGB LED.

---
 rtl/irotary_pkg.sv | 15 +
 rtl/rotary_rgb_ctrl_pwm_gen.sv | 28 ++
 rtl/rotary_rgb_ctrl.sv | 131 +++++++++++++
 tb/tb_rotary_rgb_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/irotary_pkg.sv
// Shared types and defaults for the rotary encoder RGB menu controller.
package irotary_pkg;

    localparam int unsigned N_CH_DEF  = 3;
    localparam int unsigned VAL_W_DEF = 4;

    typedef enum logic [2:0] {
        S_BROWSE,
        S_ENTER,
        S_EDIT,
        S_PRESS,
        S_WAIT_REL
    } state_t;

endpackage

// File: rtl/rotary_rgb_ctrl_pwm_gen.sv
// Free-running PWM counter shared by N_CH registered duty comparators.
module pwm_gen
    import irotary_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned VAL_W = VAL_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [N_CH*VAL_W-1:0]   duty_flat,
    output logic [N_CH-1:0]         ov_pwm
);

    logic [VAL_W-1:0] pwm_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_cnt <= '0;
            ov_pwm  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            for (int unsigned i = 0; i < N_CH; i++) begin
                ov_pwm[i] <= (pwm_cnt < duty_flat[i*VAL_W +: VAL_W]);
            end
        end
    end

endmodule

// File: rtl/rotary_rgb_ctrl.sv
// Menu controller: encoder steps browse channels or edit a shadow duty;
// short press enters/commits an edit, long press cancels it.
module rotary_rgb_ctrl
    import irotary_pkg::*;
#(
    parameter int unsigned N_CH   = N_CH_DEF,
    parameter int unsigned VAL_W  = VAL_W_DEF,
    parameter int unsigned HOLD_W = 20
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_step,
    input  logic              i_step_cw,
    input  logic              i_button,
    output logic [1:0]        o_sel,
    output logic              o_edit,
    output logic [VAL_W-1:0]  ov_val_sel,
    output logic [N_CH-1:0]   ov_pwm
);

    localparam logic [1:0]        SEL_LAST  = 2'(N_CH - 1);
    // Cancel fires on the cycle hold_cnt would reach all-ones.
    localparam logic [HOLD_W-1:0] HOLD_LAST = {{(HOLD_W-1){1'b1}}, 1'b0};

    state_t              state, state_nx;
    logic [1:0]          sel, sel_nx;
    logic [VAL_W-1:0]    val [N_CH];
    logic [VAL_W-1:0]    shadow, shadow_nx;
    logic [HOLD_W-1:0]   hold_cnt, hold_nx;
    logic                btn_q;
    logic                rise;
    logic                commit;
    logic [N_CH*VAL_W-1:0] duty_flat;

    assign rise = i_button & ~btn_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_BROWSE;
            sel      <= '0;
            shadow   <= '0;
            hold_cnt <= '0;
            btn_q    <= 1'b1;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            shadow   <= shadow_nx;
            hold_cnt <= hold_nx;
            btn_q    <= i_button;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < N_CH; i++) val[i] <= '0;
        end else if (commit) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (sel == 2'(i)) val[i] <= shadow;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        shadow_nx = shadow;
        hold_nx   = hold_cnt;
        commit    = 1'b0;
        unique case (state)
            S_BROWSE: begin
                if (rise) begin
                    state_nx  = S_ENTER;
                    shadow_nx = val[sel];
                end else if (i_step) begin
                    if (i_step_cw) sel_nx = (sel == SEL_LAST) ? 2'd0 : sel + 2'd1;
                    else           sel_nx = (sel == 2'd0) ? SEL_LAST : sel - 2'd1;
                end
            end
            S_ENTER: begin
                if (!i_button) state_nx = S_EDIT;
            end
            S_EDIT: begin
                if (rise) begin
                    state_nx = S_PRESS;
                    hold_nx  = '0;
                end else if (i_step) begin
                    if (i_step_cw) begin
                        if (shadow != '1) shadow_nx = shadow + 1'b1;
                    end else begin
                        if (shadow != '0) shadow_nx = shadow - 1'b1;
                    end
                end
            end
            S_PRESS: begin
                if (!i_button) begin
                    commit   = 1'b1;
                    state_nx = S_BROWSE;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) state_nx = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (!i_button) state_nx = S_BROWSE;
            end
            default: state_nx = S_BROWSE;
        endcase
    end

    assign o_sel      = sel;
    assign o_edit     = (state == S_ENTER) || (state == S_EDIT) || (state == S_PRESS);
    assign ov_val_sel = o_edit ? shadow : val[sel];

    always_comb begin
        duty_flat = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            duty_flat[i*VAL_W +: VAL_W] = (o_edit && sel == 2'(i)) ? shadow : val[i];
        end
    end

    pwm_gen #(
        .N_CH  (N_CH),
        .VAL_W (VAL_W)
    ) u_pwm (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .duty_flat (duty_flat),
        .ov_pwm    (ov_pwm)
    );

endmodule

// File: tb/tb_rotary_rgb_ctrl.sv
// Directed plus random bench for rotary_rgb_ctrl against a behavioural menu model.
module tb_rotary_rgb_ctrl;

    localparam int N_CH   = 3;
    localparam int VAL_W  = 4;
    localparam int HOLD_W = 4;
    localparam int VMAX   = 15;
    localparam int LONG   = 15;
    localparam int PERIOD = 16;

    localparam int M_BROWSE = 0, M_ENTER = 1, M_EDIT = 2, M_PRESS = 3, M_WAIT = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             i_step = 1'b0;
    logic             i_step_cw = 1'b0;
    logic             i_button = 1'b0;
    logic [1:0]       o_sel;
    logic             o_edit;
    logic [VAL_W-1:0] ov_val_sel;
    logic [N_CH-1:0]  ov_pwm;

    int total = 0;
    int bad   = 0;

    int       m_mode, m_sel, m_shadow, m_held, m_cnt;
    int       m_val [N_CH];
    bit       m_prev;
    bit [2:0] m_pwm;

    rotary_rgb_ctrl #(
        .N_CH   (N_CH),
        .VAL_W  (VAL_W),
        .HOLD_W (HOLD_W)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_step     (i_step),
        .i_step_cw  (i_step_cw),
        .i_button   (i_button),
        .o_sel      (o_sel),
        .o_edit     (o_edit),
        .ov_val_sel (ov_val_sel),
        .ov_pwm     (ov_pwm)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_editing();
        return (m_mode == M_ENTER) || (m_mode == M_EDIT) || (m_mode == M_PRESS);
    endfunction

    task automatic model_reset();
        m_mode = M_BROWSE; m_sel = 0; m_shadow = 0; m_held = 0; m_cnt = 0;
        m_pwm = '0; m_prev = 1'b1;
        for (int i = 0; i < N_CH; i++) m_val[i] = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit b);
        bit rise;
        int duty;
        rise = b && !m_prev;
        for (int i = 0; i < N_CH; i++) begin
            duty = (m_editing() && i == m_sel) ? m_shadow : m_val[i];
            m_pwm[i] = (m_cnt < duty);
        end
        m_cnt = (m_cnt + 1) % PERIOD;
        case (m_mode)
            M_BROWSE:
                if (rise) begin m_mode = M_ENTER; m_shadow = m_val[m_sel]; end
                else if (s) m_sel = c ? (m_sel + 1) % N_CH : (m_sel + N_CH - 1) % N_CH;
            M_ENTER:
                if (!b) m_mode = M_EDIT;
            M_EDIT:
                if (rise) begin m_mode = M_PRESS; m_held = 0; end
                else if (s) begin
                    if (c) m_shadow = (m_shadow < VMAX) ? m_shadow + 1 : VMAX;
                    else   m_shadow = (m_shadow > 0) ? m_shadow - 1 : 0;
                end
            M_PRESS:
                if (!b) begin m_val[m_sel] = m_shadow; m_mode = M_BROWSE; end
                else begin
                    m_held++;
                    if (m_held == LONG) m_mode = M_WAIT;
                end
            default:
                if (!b) m_mode = M_BROWSE;
        endcase
        m_prev = b;
    endtask

    task automatic cycle(input bit s, input bit c, input bit b);
        i_step = s; i_step_cw = c; i_button = b;
        @(posedge CLK);
        model_step(s, c, b);
        #1;
        chk("model_sel", o_sel, m_sel);
        chk("model_edit", o_edit, m_editing());
        chk("model_val_sel", ov_val_sel, m_editing() ? m_shadow : m_val[m_sel]);
        chk("model_pwm", ov_pwm, m_pwm);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel"}, o_sel, 0);
        chk({tag, "_edit"}, o_edit, 0);
        chk({tag, "_val"}, ov_val_sel, 0);
        chk({tag, "_pwm"}, ov_pwm, 0);
    endtask

    initial begin
        int sel_exp [4];
        int hi1;
        bit rb;
        sel_exp = '{1, 2, 0, 1};

        // 1. reset and browse wrap
        #2;
        chk_zero("reset");
        #10;
        RST_N = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1, 1, 0);
            chk("browse_sel", o_sel, sel_exp[k]);
            chk("browse_pwm", ov_pwm, 0);
        end

        // 2. edit channel 1 to 5 and commit with a short press
        cycle(0, 0, 1);
        chk("enter_edit", o_edit, 1);
        cycle(0, 0, 0);
        for (int k = 0; k < 5; k++) cycle(1, 1, 0);
        chk("shadow5", ov_val_sel, 5);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1);
        cycle(0, 0, 0);
        chk("commit_edit", o_edit, 0);
        chk("commit_val", ov_val_sel, 5);
        hi1 = 0;
        for (int k = 0; k < PERIOD; k++) begin
            cycle(0, 0, 0);
            if (ov_pwm[1] === 1'b1) hi1++;
        end
        chk("pwm_duty5", hi1, 5);

        // 3. saturation at both ends
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        for (int k = 0; k < 9; k++) cycle(1, 1, 0);
        chk("shadow14", ov_val_sel, 14);
        for (int k = 0; k < 4; k++) cycle(1, 1, 0);
        chk("sat_high", ov_val_sel, 15);
        for (int k = 0; k < 20; k++) cycle(1, 0, 0);
        chk("sat_low", ov_val_sel, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // 4. long press cancels
        cycle(1, 0, 0);
        chk("sel_back0", o_sel, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        for (int k = 0; k < 9; k++) cycle(1, 1, 0);
        chk("shadow9", ov_val_sel, 9);
        cycle(0, 0, 1);
        for (int k = 0; k < LONG - 1; k++) cycle(0, 0, 1);
        chk("hold_short_of_long", o_edit, 1);
        cycle(0, 0, 1);
        chk("long_cancel", o_edit, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1);
        cycle(0, 0, 0);
        chk("cancel_edit", o_edit, 0);
        chk("cancel_val", ov_val_sel, 0);

        // 5. step and rise together: button wins
        cycle(1, 1, 1);
        chk("tie_sel", o_sel, 0);
        chk("tie_edit", o_edit, 1);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // 6. asynchronous reset mid-press, button held through release
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        cycle(1, 1, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("pre_reset_edit", o_edit, 1);
        RST_N = 1'b0;
        model_reset();
        #1;
        chk_zero("async_reset");
        #2;
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1);
            chk("held_through_reset", o_edit, 0);
        end
        cycle(0, 0, 0);

        // random traffic against the model
        rb = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 7) == 0) rb = ~rb;
            cycle(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
